// File: rtl/tone_if.sv
// tone_if: decoder control inputs and note/period results between the tone source side and the decoder
interface tone_if #(parameter int CNT_W = 18);
  logic             ena;
  logic             tone_in;
  logic [2:0]       note;
  logic             note_valid;
  logic             locked;
  logic [CNT_W-1:0] period;
  modport master (output ena, tone_in, input note, note_valid, locked, period);
  modport slave  (input ena, tone_in, output note, note_valid, locked, period);
endinterface

// File: rtl/tone_decoder.sv
// tone_decoder: measures rising-edge spacing on tone_in, classifies it against the note period table
// and reports a stable locked note code (0 = silence).
module tone_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 18,
  parameter int TOL         = 2000,
  parameter int STABLE_N    = 3,
  parameter int SILENCE     = 200000,
  parameter int M_TAB [7]   = '{95600, 85150, 75850, 71600, 63750, 56800, 50600}
) (
  input logic   clk,
  input logic   rst,
  tone_if.slave bus
);
  localparam int RW = $clog2(STABLE_N + 1);
  typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;
  state_t                 st_q, st_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d, rise, match;
  logic [CNT_W-1:0]       cnt_q, cnt_d, meas, period_q, period_d;
  logic [2:0]             cls, cand_q, cand_d, note_q, note_d;
  logic [RW-1:0]          run_q, run_d, run_n;
  logic                   valid_q, valid_d, locked_q, locked_d;
  // descending scan so the lowest matching note index wins
  always_comb begin
    meas = cnt_q + CNT_W'(1);
    cls  = 3'd0;
    for (int k = 7; k >= 1; k--)
      if (int'(meas) - M_TAB[k-1] <= TOL && M_TAB[k-1] - int'(meas) <= TOL) cls = 3'(k);
  end
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.tone_in};
    prev_d   = sync_q[SYNC_STAGES-1];
    rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    match    = cls != 3'd0 && cls == cand_q;
    run_n    = match ? run_q + RW'(1) : RW'(cls != 3'd0);
    st_d     = st_q;
    cand_d   = cand_q;
    run_d    = run_q;
    note_d   = note_q;
    period_d = period_q;
    cnt_d    = rise ? '0 : cnt_q + CNT_W'(~&cnt_q);
    if (!bus.ena) begin
      st_d   = IDLE;
      cnt_d  = '0;
      run_d  = '0;
      note_d = 3'd0;
    end else if (rise) begin
      if (st_q == IDLE) begin
        st_d   = MEAS;
        run_d  = '0;
        cand_d = 3'd0;
      end else begin
        period_d = meas;
        // in LOCK cand equals note, so a mismatch restarts the run exactly like MEAS does
        if (st_q == MEAS || cls != note_q) begin
          cand_d = cls;
          run_d  = run_n;
          st_d   = (st_q == MEAS && int'(run_n) == STABLE_N) ? LOCK : MEAS;
          note_d = (st_d == LOCK) ? cls : note_q;
        end
      end
    end else if (st_q != IDLE && cnt_q == CNT_W'(SILENCE - 1)) begin
      st_d   = IDLE;
      note_d = 3'd0;
    end
    valid_d  = bus.ena && note_d != note_q;
    locked_d = st_d == LOCK;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q     <= IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      cand_q   <= 3'd0;
      run_q    <= '0;
      note_q   <= 3'd0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      note_q   <= note_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  assign bus.note       = note_q;
  assign bus.note_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.period     = period_q;
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: random square-wave stimulus against an edge-history reference model, on a
// scaled-down note table so whole melodies fit in a short run.
module tb_tone_decoder;
  localparam int SS = 2, CW = 11, TOL = 10, SN = 3, SIL = 1000;
  localparam int P [7] = '{478, 426, 379, 358, 319, 284, 253};
  logic clk = 1'b0, rst = 1'b1;
  int   n_vec = 0, n_err = 0;
  tone_if #(.CNT_W(CW)) bus ();
  tone_decoder #(.SYNC_STAGES(SS), .CNT_W(CW), .TOL(TOL), .STABLE_N(SN), .SILENCE(SIL), .M_TAB(P))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  bit have_ref, lk, dprev, m_valid;
  int m_note, m_period, last_edge, cyc;
  bit dq[$];
  int hist[$];
  function automatic int classify(int meas);
    for (int k = 1; k <= 7; k++) if (meas >= P[k-1] - TOL && meas <= P[k-1] + TOL) return k;
    return 0;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic m_clear();
    have_ref = 0; lk = 0; dprev = 0; m_valid = 0; m_note = 0; m_period = 0;
    hist.delete();
    dq.delete();
    repeat (SS) dq.push_back(1'b0);
  endtask
  // reference: lock when the last SN periods since a reference edge share one nonzero class
  task automatic m_step();
    bit d, ev, same;
    int c;
    cyc++;
    d = dq.pop_front();
    dq.push_back(bus.tone_in);
    ev = d && !dprev;
    dprev = d;
    m_valid = 0;
    if (!bus.ena) begin
      have_ref = 0; lk = 0; m_note = 0; hist.delete();
    end else if (ev) begin
      if (!have_ref) hist.delete();
      else begin
        m_period = cyc - last_edge;
        c = classify(m_period);
        if (lk) begin
          if (c != m_note) begin lk = 0; hist.delete(); hist.push_back(c); end
        end else begin
          hist.push_back(c);
          if (hist.size() > SN) void'(hist.pop_front());
          same = 1;
          foreach (hist[i]) if (hist[i] != c) same = 0;
          if (c != 0 && hist.size() == SN && same) begin
            lk = 1; m_valid = (m_note != c); m_note = c; hist.delete();
          end
        end
      end
      have_ref = 1;
      last_edge = cyc;
    end else if (have_ref && cyc - last_edge == SIL) begin
      have_ref = 0; lk = 0; m_valid = (m_note != 0); m_note = 0;
    end
  endtask
  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_clear(); else m_step();
    end
  end
  initial forever begin
    @(negedge clk);
    chk("note", bus.note, m_note);
    chk("note_valid", bus.note_valid, m_valid);
    chk("locked", bus.locked, lk);
    chk("period", bus.period, m_period);
  end
  task automatic hold(int n, bit v);
    bus.tone_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic play(int per, int n, int jit);
    for (int i = 0; i < n; i++) begin
      int p = per + $urandom_range(2 * jit, 0) - jit;
      int h = $urandom_range(p - 1, 1);
      hold(h, 1'b1);
      hold(p - h, 1'b0);
    end
  endtask
  initial begin
    int mel [7] = '{1, 1, 5, 5, 6, 6, 5};
    bus.ena = 1'b1;
    bus.tone_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_note", bus.note, 0);
    chk("rst_locked", bus.locked, 0);
    #2 rst = 1'b0;
    play(P[4], 4, 0);
    chk("m5_note", bus.note, 5);
    chk("m5_locked", bus.locked, 1);
    chk("m5_period", bus.period, P[4]);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_note", bus.note, 0);
    chk("midrst_valid", bus.note_valid, 0);
    #2 rst = 1'b0;
    play(P[4], 3, 0);
    chk("relock_early", bus.locked, 0);
    play(P[4], 1, 0);
    chk("relock_edge4", bus.locked, 1);
    hold(SIL + 20, 1'b0);
    chk("sil_note", bus.note, 0);
    play(P[0] + TOL, 4, 0);
    chk("tol_in", bus.note, 1);
    hold(SIL + 20, 1'b0);
    play(P[0] + TOL + 1, 6, 0);
    chk("tol_out_note", bus.note, 0);
    chk("tol_out_locked", bus.locked, 0);
    hold(SIL + 20, 1'b0);
    play(P[4], 4, 0);
    play(P[2], 2, 0);
    chk("sw_unlock", bus.locked, 0);
    chk("sw_hold", bus.note, 5);
    play(P[2], 2, 0);
    chk("sw_note", bus.note, 3);
    hold(SIL + 20, 1'b0);
    play(P[6], 4, 0);
    chk("m7_note", bus.note, 7);
    hold(SIL + 20, 1'b0);
    chk("m7_sil_note", bus.note, 0);
    chk("m7_sil_locked", bus.locked, 0);
    play(P[6], 4, 0);
    bus.ena = 1'b0;
    hold(5, 1'b0);
    chk("ena_note", bus.note, 0);
    chk("ena_locked", bus.locked, 0);
    bus.ena = 1'b1;
    foreach (mel[i]) begin
      play(P[mel[i]-1], 4, 0);
      chk("mel_note", bus.note, mel[i]);
      chk("mel_period", bus.period, P[mel[i]-1]);
      hold(SIL + 30, 1'b1);
      chk("mel_gap", bus.note, 0);
      hold(3, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      play(P[$urandom_range(6, 0)], 5, TOL);
      if ($urandom_range(2, 0) == 0) begin hold(2, 1'b1); hold(2, 1'b0); end
      if ($urandom_range(4, 0) == 0) begin bus.ena = 1'b0; hold(3, 1'b0); bus.ena = 1'b1; end
    end
    hold(SIL + 20, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
